window_gen: RTL
===============

Name: window_gen

Overview:
- Parametrised successor to the 3x3 pixel loader: accepts a raster-order pixel stream and emits KxK neighbourhood windows for the Gaussian/Sobel stages of the Canny pipeline.
- Adds generic pixel width, image size and window size.
- Adds a valid/ready handshake with backpressure, frame-position tracking and a frame-done pulse.
- Sits between the pixel source and the convolution kernels.

Parameters:
- PIX_W, 8, bits per pixel.
- IMG_W, 512, pixels per line (>= K).
- IMG_H, 512, lines per frame (>= K).
- K, 3, window side; odd, 3..7; elaboration error otherwise.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- pixel_in  in  PIX_W  input pixel, raster order.
- pixel_in_valid  in  1  pixel_in is valid.
- pixel_in_ready  out  1  block can accept a pixel this cycle.
- pixel_data_out  out  K*K*PIX_W  window; slot i = r*K+c at [i*PIX_W +: PIX_W]; r=0 top row, c=0 left column; slot K*K-1 = newest pixel.
- pixel_data_out_valid  out  1  window valid.
- pixel_data_out_ready  in  1  downstream accepts window.
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted.

Behaviour:
- Reset (rst=1 at an edge):
  - Clears col/row counters to 0; pixel_data_out_valid=0, frame_done=0, pixel_data_out=0.
  - Line-buffer RAM and window registers need not be cleared.
  - Reset mid-frame discards the partial frame; the next accepted pixel is (0,0).
- Handshake:
  - pixel_in_ready = !pixel_data_out_valid || pixel_data_out_ready (combinational, no other stall source).
  - A pixel is accepted when pixel_in_valid && pixel_in_ready.
  - While pixel_data_out_valid && !pixel_data_out_ready, pixel_data_out is held stable and no input is accepted.
- Per accepted pixel at (row,col):
  - Window registers shift one column left.
  - The new right column is {line_buf[K-2]..line_buf[0] read at col, pixel_in}, top to bottom.
  - Line buffers cascade: buf[0] written with pixel_in, buf[j] with buf[j-1]'s read value, same address col (read-before-write).
- Output:
  - pixel_data_out_valid is set on the edge after acceptance iff row >= K-1 and col >= K-1. Latency is 1 cycle from acceptance.
  - The window centre is (row-(K-1)/2, col-(K-1)/2).
  - Otherwise valid clears on that edge if the prior window was consumed.
  - Windows straddling a line wrap are never flagged valid.
  - Per frame: exactly (IMG_H-K+1)*(IMG_W-K+1) windows (512x512, K=3: 260100).
- Counters:
  - col increments per accepted pixel and wraps at IMG_W-1, then row increments.
  - At (IMG_H-1, IMG_W-1) both wrap to 0 and frame_done pulses on the next edge.
  - Back-to-back frames need no gap. Stale line-buffer data is masked by the row>=K-1 gate.
- Counter widths are $clog2(IMG_W) and $clog2(IMG_H); there is no arithmetic overflow beyond wrap.
- Accept and output-consume in the same cycle is legal and sustains 1 pixel/clock.

Optional Feature:
- Macro WINDOW_GEN_COORD_EN.
- When defined: adds outputs win_row [$clog2(IMG_H)] and win_col [$clog2(IMG_W)], giving the window-centre coordinates. They are registered with and held alongside pixel_data_out, and reset to 0.
- When undefined: these ports and their registers are absent, and behaviour is otherwise identical.

Decomposition:
- Package canny_pkg holds:
  - PIX_W default constant.
  - typedef pixel_t (logic [PIX_W-1:0]).
  - function win_idx(r,c) = r*K+c.
- Sub-module line_buffer: IMG_W-deep, PIX_W-wide circular store with one address, read-before-write, and a write enable. window_gen instantiates K-1 of them.
- The window shift array and counters stay in window_gen.

Test Plan:
- Small image, IMG_W=8, IMG_H=6, K=3, pixel = row*16+col, continuous valid and ready=1:
  - first valid window appears 1 cycle after accepting (2,2), with slots 0..8 = 00,01,02,10,11,12,20,21,22;
  - exactly 24 windows;
  - frame_done pulses once after pixel 0x57.
- Same image with ready toggled 1/0 every cycle:
  - pixel_in_ready follows the handshake rule;
  - windows are held stable while stalled;
  - the window sequence is identical to the no-stall run; no drops or duplicates.
- Two back-to-back frames, no gap:
  - the second frame's 24 windows match the first;
  - no valid window is produced for rows 0-1 of frame 2.
- rst=1 for one cycle after pixel (3,4), then restart the stream:
  - valid is 0 the cycle after reset;
  - the first window again appears after (2,2) with contents 00..22.
- K=5, IMG_W=8, IMG_H=8:
  - first window appears after (4,4) with slot 0 = 00 and slot 24 = 44;
  - 16 windows total.
- WINDOW_GEN_COORD_EN defined, the K=3 case above:
  - first window reports win_row=1, win_col=1;
  - last window reports win_row=4, win_col=6.

Source files
------------

// File: rtl/canny_pkg.sv
// Shared types and helpers for the Canny front-end blocks (window generator, line buffers).
package canny_pkg;

    localparam int PIX_W_DEFAULT = 8;

    typedef logic [PIX_W_DEFAULT-1:0] pixel_t;

    // Flat slot number of window element (r, c) in a k x k window, row-major, r=0 top.
    function automatic int win_idx(input int r, input int c, input int k);
        return r * k + c;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One image line of pixel history: circular store addressed by column, read-before-write.
// The read is combinational at addr, so the old value is visible in the same cycle the new one is written.
module line_buffer #(
    parameter int PIX_W = 8,
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] wr_data,
    output logic [PIX_W-1:0] rd_data
);

    logic [PIX_W-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/window_gen.sv
// Raster pixel stream to KxK neighbourhood windows with valid/ready flow control and frame tracking.
// Optional window-centre coordinate outputs are enabled by defining WINDOW_GEN_COORD_EN.
module window_gen
    import canny_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEFAULT,
    parameter int IMG_W = 512,
    parameter int IMG_H = 512,
    parameter int K     = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PIX_W-1:0]       pixel_in,
    input  logic                   pixel_in_valid,
    output logic                   pixel_in_ready,
    output logic [K*K*PIX_W-1:0]   pixel_data_out,
    output logic                   pixel_data_out_valid,
    input  logic                   pixel_data_out_ready,
    output logic                   frame_done
`ifdef WINDOW_GEN_COORD_EN
    ,
    output logic [$clog2(IMG_H)-1:0] win_row,
    output logic [$clog2(IMG_W)-1:0] win_col
`endif
);

    localparam int CW   = $clog2(IMG_W);
    localparam int RW   = $clog2(IMG_H);
    localparam int HALF = (K - 1) / 2;

    generate
        if (K < 3 || K > 7 || (K % 2) == 0) begin : g_bad_k
            $error("window_gen: K must be odd and in 3..7");
        end
        if (IMG_W < K || IMG_H < K) begin : g_bad_img
            $error("window_gen: IMG_W and IMG_H must be >= K");
        end
    endgenerate

    logic [CW-1:0] col_reg, col_next;
    logic [RW-1:0] row_reg, row_next;
    logic          valid_reg, valid_next;
    logic          frame_done_reg, frame_done_next;
    logic          accept;
    logic          col_last, row_last, win_hit;

    logic [PIX_W-1:0] win_reg [K][K];
    logic [PIX_W-1:0] col_in  [K];
    logic [PIX_W-1:0] lb_wr   [K-1];
    logic [PIX_W-1:0] lb_rd   [K-1];

    assign pixel_in_ready = !valid_reg || pixel_data_out_ready;
    assign accept         = pixel_in_valid && pixel_in_ready;

    always_comb begin
        col_next        = col_reg;
        row_next        = row_reg;
        valid_next      = valid_reg;
        frame_done_next = 1'b0;
        col_last        = (col_reg == CW'(IMG_W - 1));
        row_last        = (row_reg == RW'(IMG_H - 1));
        // A window is complete only once K rows and K columns of the current line are in.
        win_hit         = (row_reg >= RW'(K - 1)) && (col_reg >= CW'(K - 1));

        if (accept) begin
            if (col_last) begin
                col_next = '0;
                row_next = row_last ? '0 : row_reg + 1'b1;
            end else begin
                col_next = col_reg + 1'b1;
            end
            frame_done_next = col_last && row_last;
            valid_next      = win_hit;
        end else if (pixel_data_out_ready) begin
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_reg        <= '0;
            row_reg        <= '0;
            valid_reg      <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            col_reg        <= col_next;
            row_reg        <= row_next;
            valid_reg      <= valid_next;
            frame_done_reg <= frame_done_next;
        end
    end

    assign pixel_data_out_valid = valid_reg;
    assign frame_done           = frame_done_reg;

    // Line buffers cascade: buffer 0 holds the previous line, buffer K-2 the oldest.
    genvar gi;
    generate
        for (gi = 0; gi < K - 1; gi++) begin : g_lb
            if (gi == 0) begin : g_first
                assign lb_wr[gi] = pixel_in;
            end else begin : g_chain
                assign lb_wr[gi] = lb_rd[gi-1];
            end

            line_buffer #(
                .PIX_W (PIX_W),
                .DEPTH (IMG_W),
                .AW    (CW)
            ) u_line_buffer (
                .clk     (clk),
                .we      (accept),
                .addr    (col_reg),
                .wr_data (lb_wr[gi]),
                .rd_data (lb_rd[gi])
            );
        end

        for (gi = 0; gi < K; gi++) begin : g_col_in
            if (gi == K - 1) begin : g_newest
                assign col_in[gi] = pixel_in;
            end else begin : g_hist
                assign col_in[gi] = lb_rd[K-2-gi];
            end
        end
    endgenerate

    // Window shift array: each accepted pixel moves the window one column left.
    generate
        for (gi = 0; gi < K * K; gi++) begin : g_win
            localparam int R   = gi / K;
            localparam int C   = gi % K;
            localparam int IDX = win_idx(R, C, K);

            if (C < K - 1) begin : g_shift
                always_ff @(posedge clk) begin
                    if (rst) begin
                        win_reg[R][C] <= '0;
                    end else if (accept) begin
                        win_reg[R][C] <= win_reg[R][C+1];
                    end
                end
            end else begin : g_load
                always_ff @(posedge clk) begin
                    if (rst) begin
                        win_reg[R][C] <= '0;
                    end else if (accept) begin
                        win_reg[R][C] <= col_in[R];
                    end
                end
            end

            assign pixel_data_out[IDX*PIX_W +: PIX_W] = win_reg[R][C];
        end
    endgenerate

`ifdef WINDOW_GEN_COORD_EN
    logic [RW-1:0] win_row_reg;
    logic [CW-1:0] win_col_reg;

    // Captured with the window, so the coordinates stay aligned through stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_row_reg <= '0;
            win_col_reg <= '0;
        end else if (accept) begin
            win_row_reg <= row_reg - RW'(HALF);
            win_col_reg <= col_reg - CW'(HALF);
        end
    end

    assign win_row = win_row_reg;
    assign win_col = win_col_reg;
`endif

endmodule
